// File: rtl/bus_pkg.sv
// Shared types and memory-map constants for the SVNES CPU bus.
package bus_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam logic [15:0] CPU_RAM_BASE     = 16'h0000;
  localparam int          CPU_RAM_WIN_LOG2 = 13;
endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM: one write port, registered read, read-first.
module ram_sp
  import bus_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ram.sv
// CPU-bus memory: window decode with mirroring, write-protected low region,
// RD_LAT-deep read pipeline, open-bus hold and a side-band preload port.
module bus_ram
  import bus_pkg::*;
#(
  parameter int            AW         = 16,
  parameter int            DW         = 8,
  parameter int            DEPTH_LOG2 = 11,
  parameter int            WIN_LOG2   = CPU_RAM_WIN_LOG2,
  parameter logic [AW-1:0] BASE       = AW'(CPU_RAM_BASE),
  parameter int            RD_LAT     = 1,
  parameter int            ROM_WORDS  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stb,
  input  logic [AW-1:0]         addr,
  input  logic                  rw,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata,
  output logic                  rdata_oe,
  output logic                  rvalid,
  output logic                  hit,
  output logic                  wp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DW-1:0]         ld_data,
  output logic                  collide
);

  localparam logic [DEPTH_LOG2:0] ROM_LIM = (DEPTH_LOG2+1)'(ROM_WORDS);

  logic [DEPTH_LOG2-1:0] idx;
  logic                  prot;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  acc_p0;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DW-1:0]         ram_wdata;
  logic [DW-1:0]         ram_q;
  logic                  vld_p0, vld_p1, vld_p2, vld_p3;
  logic [DW-1:0]         dat_p1, dat_p2, dat_p3;
  logic                  exit_vld;
  logic [DW-1:0]         exit_dat;

  assign hit  = (addr >> WIN_LOG2) == (BASE >> WIN_LOG2);
  assign idx  = addr[DEPTH_LOG2-1:0];
  assign prot = {1'b0, idx} < ROM_LIM;

  // The load port owns the array whenever ld_en is high; a coincident strobe is dropped.
  assign acc    = stb & ~reset & ~ld_en;
  assign rd_acc = acc & hit & rw;
  assign wr_acc = acc & hit & ~rw;

  assign ram_we    = ld_en | (wr_acc & ~prot);
  assign ram_addr  = ld_en ? ld_addr : idx;
  assign ram_wdata = ld_en ? ld_data : wdata;

  ram_sp #(
    .DW (DW),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (rd_acc),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Stage p0..p3: read tags shift alongside the array output
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    dat_p1 <= ram_q;
    dat_p2 <= dat_p1;
    dat_p3 <= dat_p2;
  end

  always_comb begin
    exit_vld = vld_p3;
    exit_dat = dat_p3;
    case (RD_LAT)
      1: begin exit_vld = vld_p0; exit_dat = ram_q;  end
      2: begin exit_vld = vld_p1; exit_dat = dat_p1; end
      3: begin exit_vld = vld_p2; exit_dat = dat_p2; end
      default: begin exit_vld = vld_p3; exit_dat = dat_p3; end
    endcase
  end

  // Output stage: open-bus hold, drive enable released one cycle after any strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rdata_oe <= 1'b0;
      rvalid   <= 1'b0;
      wp_err   <= 1'b0;
      collide  <= 1'b0;
      acc_p0   <= 1'b0;
    end else begin
      rvalid   <= exit_vld;
      if (exit_vld) rdata <= exit_dat;
      rdata_oe <= exit_vld | (rdata_oe & ~acc_p0);
      wp_err   <= wr_acc & prot;
      collide  <= stb & ld_en;
      acc_p0   <= acc;
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: three parameterisations share one stimulus stream and are
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_bus_ram;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stb, rw, ld_en;
  addr_t       addr;
  data_t       wdata, ld_data;
  logic [10:0] ld_addr;

  data_t       rdata_v [3];
  logic  [2:0] oe_v, rvalid_v, hit_v, wp_v, col_v;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_ram #(.RD_LAT(1)) u_d0 (
    .clk(clk), .reset(reset), .stb(stb), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata_v[0]), .rdata_oe(oe_v[0]), .rvalid(rvalid_v[0]), .hit(hit_v[0]),
    .wp_err(wp_v[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .collide(col_v[0]));

  bus_ram #(.RD_LAT(3), .ROM_WORDS(256)) u_d1 (
    .clk(clk), .reset(reset), .stb(stb), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata_v[1]), .rdata_oe(oe_v[1]), .rvalid(rvalid_v[1]), .hit(hit_v[1]),
    .wp_err(wp_v[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .collide(col_v[1]));

  bus_ram #(.RD_LAT(4)) u_d2 (
    .clk(clk), .reset(reset), .stb(stb), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata_v[2]), .rdata_oe(oe_v[2]), .rvalid(rvalid_v[2]), .hit(hit_v[2]),
    .wp_err(wp_v[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .collide(col_v[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int rom_of(input int i);
    return (i == 1) ? 256 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image plus a calendar of read results keyed by due cycle
  data_t mem   [3][2048];
  bit    memk  [3][2048];
  bit    pv    [3][8];
  data_t pd    [3][8];
  bit    pk    [3][8];
  data_t m_rd  [3];
  bit    m_rk  [3];
  bit    m_oe  [3];
  bit    m_rv  [3];
  bit    m_wp  [3];
  bit    m_col [3];
  bit    m_prev[3];
  int    cyc = 0;

  task automatic model_step(input int i);
    int  s, ix;
    bit  acc, h;
    if (reset) begin
      m_rd[i] = '0; m_rk[i] = 1'b1; m_oe[i] = 1'b0; m_rv[i] = 1'b0;
      m_wp[i] = 1'b0; m_col[i] = 1'b0; m_prev[i] = 1'b0;
      for (int k = 0; k < 8; k++) pv[i][k] = 1'b0;
    end else begin
      s = cyc % 8;
      m_rv[i] = pv[i][s];
      if (pv[i][s]) begin
        m_rd[i] = pd[i][s];
        m_rk[i] = pk[i][s];
        pv[i][s] = 1'b0;
      end
      if (m_rv[i])        m_oe[i] = 1'b1;
      else if (m_prev[i]) m_oe[i] = 1'b0;
      acc       = stb && !ld_en;
      m_prev[i] = acc;
      m_col[i]  = stb && ld_en;
      h  = (int'(addr) / 8192) == 0;
      ix = int'(addr) % 2048;
      m_wp[i] = 1'b0;
      if (acc && h && rw) begin
        s = (cyc + lat_of(i)) % 8;
        pv[i][s] = 1'b1;
        pd[i][s] = mem[i][ix];
        pk[i][s] = memk[i][ix];
      end
      if (acc && h && !rw) begin
        if (ix < rom_of(i)) m_wp[i] = 1'b1;
        else begin
          mem[i][ix]  = wdata;
          memk[i][ix] = 1'b1;
        end
      end
    end
    if (ld_en) begin
      mem[i][ld_addr]  = ld_data;
      memk[i][ld_addr] = 1'b1;
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rvalid[%0d]", i), 32'(rvalid_v[i]), 32'(m_rv[i]));
      chk($sformatf("rdata_oe[%0d]", i), 32'(oe_v[i]), 32'(m_oe[i]));
      chk($sformatf("wp_err[%0d]", i), 32'(wp_v[i]), 32'(m_wp[i]));
      chk($sformatf("collide[%0d]", i), 32'(col_v[i]), 32'(m_col[i]));
      chk($sformatf("hit[%0d]", i), 32'(hit_v[i]), 32'((int'(addr) / 8192) == 0));
      if (m_rk[i]) chk($sformatf("rdata[%0d]", i), 32'(rdata_v[i]), 32'(m_rd[i]));
    end
  end

  task automatic drive(input logic r, input logic s, input logic w_rw, input addr_t a,
                       input data_t wd, input logic le, input logic [10:0] la,
                       input data_t ldv);
    reset = r; stb = s; rw = w_rw; addr = a; wdata = wd;
    ld_en = le; ld_addr = la; ld_data = ldv;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 11'h0, 8'h00);
  endtask

  task automatic load(input logic [10:0] la, input data_t d);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, la, d);
  endtask

  task automatic bus_wr(input addr_t a, input data_t d);
    drive(1'b0, 1'b1, 1'b0, a, d, 1'b0, 11'h0, 8'h00);
  endtask

  task automatic bus_rd(input addr_t a);
    drive(1'b0, 1'b1, 1'b1, a, 8'h00, 1'b0, 11'h0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; stb = 1'b0; rw = 1'b1; addr = '0; wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    chk("reset rdata", 32'(rdata_v[0]), 32'h0);
    chk("reset rdata_oe", 32'(oe_v[0]), 32'h0);
    chk("reset rvalid", 32'(rvalid_v[2]), 32'h0);

    load(11'h000, 8'h11);
    load(11'h001, 8'h22);
    load(11'h002, 8'h33);
    load(11'h010, 8'h3C);
    load(11'h020, 8'h44);
    load(11'h7FF, 8'hE7);

    // mirroring
    bus_wr(16'h0005, 8'hA5);
    bus_rd(16'h0805);
    idle();
    chk("mirror rvalid", 32'(rvalid_v[0]), 32'h1);
    chk("mirror rdata", 32'(rdata_v[0]), 32'hA5);
    chk("mirror rdata_oe", 32'(oe_v[0]), 32'h1);

    // write protect
    bus_wr(16'h0010, 8'hFF);
    chk("wp_err rom", 32'(wp_v[1]), 32'h1);
    chk("wp_err no rom", 32'(wp_v[0]), 32'h0);
    bus_rd(16'h0010);
    repeat (3) idle();
    chk("wp read rvalid", 32'(rvalid_v[1]), 32'h1);
    chk("wp read rom", 32'(rdata_v[1]), 32'h3C);
    chk("wp read ram", 32'(rdata_v[0]), 32'hFF);

    // latency and ordering
    bus_rd(16'h0000);
    bus_rd(16'h0001);
    bus_rd(16'h0002);
    idle();
    chk("lat3 first", 32'(rdata_v[1]), 32'h11);
    chk("lat3 first vld", 32'(rvalid_v[1]), 32'h1);
    idle();
    chk("lat3 second", 32'(rdata_v[1]), 32'h22);
    idle();
    chk("lat3 third", 32'(rdata_v[1]), 32'h33);
    idle();
    chk("lat3 drained", 32'(rvalid_v[1]), 32'h0);

    // open bus
    load(11'h001, 8'h77);
    bus_rd(16'h0001);
    bus_rd(16'h2000);
    chk("miss hit", 32'(hit_v[0]), 32'h0);
    chk("open read rdata", 32'(rdata_v[0]), 32'h77);
    chk("open read oe", 32'(oe_v[0]), 32'h1);
    idle();
    chk("open bus rvalid", 32'(rvalid_v[0]), 32'h0);
    chk("open bus rdata", 32'(rdata_v[0]), 32'h77);
    chk("open bus oe", 32'(oe_v[0]), 32'h0);

    // window top wraps onto the last physical word
    bus_rd(16'h1FFF);
    chk("wrap hit", 32'(hit_v[0]), 32'h1);
    idle();
    chk("wrap rdata", 32'(rdata_v[0]), 32'hE7);

    // collision
    drive(1'b0, 1'b1, 1'b0, 16'h0007, 8'hC3, 1'b1, 11'h007, 8'h5A);
    chk("collide", 32'(col_v[0]), 32'h1);
    bus_rd(16'h0007);
    idle();
    chk("collide rdata", 32'(rdata_v[0]), 32'h5A);

    // reset with reads in flight; the concurrent write must be ignored
    repeat (4) idle();
    bus_rd(16'h0002);
    idle();
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 8'h99, 1'b0, 11'h0, 8'h00);
    repeat (4) idle();
    chk("flight rvalid", 32'(rvalid_v[2]), 32'h0);
    chk("flight rdata", 32'(rdata_v[2]), 32'h0);
    chk("flight oe", 32'(oe_v[2]), 32'h0);
    bus_rd(16'h0020);
    idle();
    chk("reset write ignored", 32'(rdata_v[0]), 32'h44);

    repeat (6) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
